triangle_channel_ctrl: RTL
==========================

TRIANGLE_CHANNEL_CTRL -- requirements
Module: triangle_channel_ctrl

Interface
REQ-001 The block SHALL use reset iReset, asynchronous, active-high, and clock iClk.
REQ-002 Port iClk  input  1  APU/CPU clock; all state changes on its rising edge.
REQ-003 Port iReset  input  1  asynchronous active-high reset.
REQ-004 Port iWrEn  input  1  register write strobe, one cycle per write.
REQ-005 Port iAddr  input  2  register select: 0=$4008, 1=$4009 (ignored), 2=$400A, 3=$400B.
REQ-006 Port iData  input  8  write data.
REQ-007 Port iChanEn  input  1  channel enable, $4015 bit 2, level.
REQ-008 Port iQuarterFrame  input  1  frame-sequencer quarter-frame pulse, one cycle.
REQ-009 Port iHalfFrame  input  1  frame-sequencer half-frame pulse, one cycle.
REQ-010 Port oStep  output  1  one-cycle registered enable pulse to the triangle waveform generator.
REQ-011 Port oActive  output  1  length counter nonzero, for $4015 status read.

Function
REQ-012 $4008 write SHALL store ctrl flag = iData[7] and linear reload value R = iData[6:0].
REQ-013 $400A write SHALL store period P[7:0] = iData; $400B write SHALL store P[10:8] = iData[2:0].
REQ-014 Period writes SHALL NOT restart the timer; the new P takes effect at the next timer reload.
REQ-015 $400B write with iChanEn=1 SHALL load the length counter from table[iData[7:3]], table = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
REQ-016 Every $400B write SHALL set the linear reload flag, regardless of iChanEn.
REQ-017 While iChanEn=0, the length counter SHALL be forced to 0 on every cycle; $400B length loads are ignored.
REQ-018 Timer: 11-bit down counter; at count 0 it SHALL reload P, otherwise it SHALL decrement, giving one expiry every P+1 cycles.
REQ-019 oStep SHALL be 1 for exactly the cycle after a timer expiry iff length!=0, linear!=0 and P>=2; otherwise 0. P<2 silences the channel (ultrasonic suppression).
REQ-020 On iQuarterFrame, the linear counter SHALL load R if the reload flag is 1, else decrement if nonzero; the reload flag SHALL then clear if ctrl flag=0.
REQ-021 On iHalfFrame, the length counter SHALL decrement if it is nonzero and ctrl flag=0 (halt clear); it holds at 0 (no wrap).
REQ-022 Simultaneous quarter and half frame: both SHALL be applied in the same cycle.
REQ-023 $400B write coincident with iHalfFrame: the table load SHALL win over the decrement.
REQ-024 $400B write coincident with iQuarterFrame: the quarter-frame action SHALL use the old reload flag, and the flag SHALL be 1 afterwards.
REQ-025 oActive SHALL equal (length counter != 0), registered, with one-cycle latency after the counter changes.
REQ-026 $4009 writes SHALL have no effect.

Reset
REQ-027 While iReset=1, ctrl flag, R, P, timer, linear counter, length counter and reload flag SHALL be 0, and oStep=0, oActive=0.
REQ-028 Reset asserted mid-operation SHALL clear state immediately (asynchronously); after release, oStep stays 0 until length and linear are both reloaded.

Verification
REQ-029 iChanEn=1; write $4008=0x81, $400A=0x04, $400B=0x08; one iQuarterFrame -> length=254, linear=1, oActive=1, oStep pulses every 5 cycles.
REQ-030 Same state plus iHalfFrame -> length stays 254 (ctrl=1). Rewrite $4008=0x01 and pulse iHalfFrame -> length=253.
REQ-031 Drop iChanEn -> oActive=0 within 2 cycles and oStep stops; $400B=0x08 while disabled -> length stays 0.
REQ-032 ctrl=0, R=2, $400B written; quarter frames -> linear 2,1,0; oStep ceases after linear reaches 0.
REQ-033 P=1 with length and linear nonzero -> oStep never asserts; write $400A=0x02 -> pulses every 3 cycles after the next reload.
REQ-034 $400B write coincident with iHalfFrame and iQuarterFrame -> length=table value, reload flag=1. Assert iReset mid-stream -> all outputs 0 the same cycle.

Source files
------------

// File: rtl/triangle_channel_ctrl.sv
// Triangle channel control: register decode, period timer, linear and length counters.
// Produces the step enable for the waveform sequencer and the $4015 active status bit.
module triangle_channel_ctrl (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iWrEn,
    input  logic [1:0] iAddr,
    input  logic [7:0] iData,
    input  logic       iChanEn,
    input  logic       iQuarterFrame,
    input  logic       iHalfFrame,
    output logic       oStep,
    output logic       oActive
);

    localparam int unsigned PERIOD_W = 11;
    localparam int unsigned LIN_W    = 7;
    localparam int unsigned LEN_W    = 8;

    logic                ctrlFlag,   ctrlFlagNext;
    logic [LIN_W-1:0]    reloadVal,  reloadValNext;
    logic [PERIOD_W-1:0] period,     periodNext;
    logic [PERIOD_W-1:0] timer,      timerNext;
    logic [LIN_W-1:0]    linearCnt,  linearCntNext;
    logic [LEN_W-1:0]    lengthCnt,  lengthCntNext;
    logic                reloadFlag, reloadFlagNext;
    logic                stepNext;
    logic                activeNext;

    logic wr4008;
    logic wr400A;
    logic wr400B;
    logic timerExpired;

    // Length counter load table indexed by $400B bits 7:3
    function automatic logic [LEN_W-1:0] lengthLookup(input logic [4:0] idx);
        case (idx)
            5'd0:  lengthLookup = LEN_W'(10);
            5'd1:  lengthLookup = LEN_W'(254);
            5'd2:  lengthLookup = LEN_W'(20);
            5'd3:  lengthLookup = LEN_W'(2);
            5'd4:  lengthLookup = LEN_W'(40);
            5'd5:  lengthLookup = LEN_W'(4);
            5'd6:  lengthLookup = LEN_W'(80);
            5'd7:  lengthLookup = LEN_W'(6);
            5'd8:  lengthLookup = LEN_W'(160);
            5'd9:  lengthLookup = LEN_W'(8);
            5'd10: lengthLookup = LEN_W'(60);
            5'd11: lengthLookup = LEN_W'(10);
            5'd12: lengthLookup = LEN_W'(14);
            5'd13: lengthLookup = LEN_W'(12);
            5'd14: lengthLookup = LEN_W'(26);
            5'd15: lengthLookup = LEN_W'(14);
            5'd16: lengthLookup = LEN_W'(12);
            5'd17: lengthLookup = LEN_W'(16);
            5'd18: lengthLookup = LEN_W'(24);
            5'd19: lengthLookup = LEN_W'(18);
            5'd20: lengthLookup = LEN_W'(48);
            5'd21: lengthLookup = LEN_W'(20);
            5'd22: lengthLookup = LEN_W'(96);
            5'd23: lengthLookup = LEN_W'(22);
            5'd24: lengthLookup = LEN_W'(192);
            5'd25: lengthLookup = LEN_W'(24);
            5'd26: lengthLookup = LEN_W'(72);
            5'd27: lengthLookup = LEN_W'(26);
            5'd28: lengthLookup = LEN_W'(16);
            5'd29: lengthLookup = LEN_W'(28);
            5'd30: lengthLookup = LEN_W'(32);
            default: lengthLookup = LEN_W'(30);
        endcase
    endfunction

    assign wr4008       = iWrEn && (iAddr == 2'd0);
    assign wr400A       = iWrEn && (iAddr == 2'd2);
    assign wr400B       = iWrEn && (iAddr == 2'd3);
    assign timerExpired = (timer == PERIOD_W'(0));

    // Next-state logic for all channel control state
    always_comb begin
        ctrlFlagNext   = ctrlFlag;
        reloadValNext  = reloadVal;
        periodNext     = period;
        timerNext      = timer;
        linearCntNext  = linearCnt;
        lengthCntNext  = lengthCnt;
        reloadFlagNext = reloadFlag;

        if (wr4008) begin
            ctrlFlagNext  = iData[7];
            reloadValNext = iData[6:0];
        end
        if (wr400A) begin
            periodNext[7:0] = iData;
        end
        if (wr400B) begin
            periodNext[10:8] = iData[2:0];
        end

        // Reload uses the period currently held, so period writes never restart a count
        if (timerExpired) begin
            timerNext = period;
        end else begin
            timerNext = timer - PERIOD_W'(1);
        end

        if (iQuarterFrame) begin
            if (reloadFlag) begin
                linearCntNext = reloadVal;
            end else if (linearCnt != LIN_W'(0)) begin
                linearCntNext = linearCnt - LIN_W'(1);
            end
            if (!ctrlFlag) begin
                reloadFlagNext = 1'b0;
            end
        end
        // A $400B write always leaves the reload flag set, even alongside a quarter frame
        if (wr400B) begin
            reloadFlagNext = 1'b1;
        end

        if (!iChanEn) begin
            lengthCntNext = LEN_W'(0);
        end else if (wr400B) begin
            lengthCntNext = lengthLookup(iData[7:3]);
        end else if (iHalfFrame && !ctrlFlag && (lengthCnt != LEN_W'(0))) begin
            lengthCntNext = lengthCnt - LEN_W'(1);
        end
    end

    // Step is suppressed for periods below 2 to keep the channel out of the ultrasonic range
    always_comb begin
        stepNext   = timerExpired && (lengthCnt != LEN_W'(0)) &&
                     (linearCnt != LIN_W'(0)) && (period >= PERIOD_W'(2));
        activeNext = (lengthCnt != LEN_W'(0));
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            ctrlFlag   <= 1'b0;
            reloadVal  <= '0;
            period     <= '0;
            timer      <= '0;
            linearCnt  <= '0;
            lengthCnt  <= '0;
            reloadFlag <= 1'b0;
            oStep      <= 1'b0;
            oActive    <= 1'b0;
        end else begin
            ctrlFlag   <= ctrlFlagNext;
            reloadVal  <= reloadValNext;
            period     <= periodNext;
            timer      <= timerNext;
            linearCnt  <= linearCntNext;
            lengthCnt  <= lengthCntNext;
            reloadFlag <= reloadFlagNext;
            oStep      <= stepNext;
            oActive    <= activeNext;
        end
    end

endmodule
